serial_sub_ctrl: RTL and testbench

- Sequences a single shared 1-bit full subtractor cell to compute a WIDTH-bit subtraction `a - b - borrow`, bit-serially, LSB first.
- The subtractor cell itself stays external. This block owns:
  - the operand shift registers,
  - the borrow flip-flop,
  - the bit counter,
  - the start/done handshake.
- Sits between a requester issuing multi-bit subtract commands and the 1-bit subtractor instance.

---
 rtl/serial_sub_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a-b-borrow sequencer around an external 1-bit full subtractor (optional overflow flag: SERIAL_SUB_OVF_EN)
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf_out,
`endif
  output logic             fs_a_out,
  output logic             fs_b_out,
  output logic             fs_borrow_out,
  input  logic             fs_diff_in,
  input  logic             fs_borrow_in
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow_reg;
  logic [CW-1:0]    count;
  logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // The final bit is being processed when RUN reaches count WIDTH-1.
  assign last_bit = (state == RUN) && (count == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the handshake / subtractor-drive outputs.
  always_comb begin
    state_nxt     = state;
    busy_out      = 1'b0;
    done_out      = 1'b0;
    fs_a_out      = 1'b0;
    fs_b_out      = 1'b0;
    fs_borrow_out = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) state_nxt = RUN;
      end
      RUN: begin
        busy_out      = 1'b1;
        fs_a_out      = a_sh[0];
        fs_b_out      = b_sh[0];
        fs_borrow_out = borrow_reg;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy_out  = 1'b1;
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shifting, borrow chain, bit counter and held result.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      borrow_reg <= 1'b0;
      count      <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf_out    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            a_sh       <= a_in;
            b_sh       <= b_in;
            borrow_reg <= borrow_in;
            count      <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= a_in[WIDTH-1];
            b_msb      <= b_in[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh       <= a_sh >> 1;
          b_sh       <= b_sh >> 1;
          res_sh     <= {fs_diff_in, res_sh[WIDTH-1:1]};
          borrow_reg <= fs_borrow_in;
          count      <= count + CW'(1);
          if (last_bit) begin
            // The result register is not yet updated with the final bit, so splice it in here.
            diff_out   <= {fs_diff_in, res_sh[WIDTH-1:1]};
            borrow_out <= fs_borrow_in;
`ifdef SERIAL_SUB_OVF_EN
            ovf_out    <= (a_msb != b_msb) && (fs_diff_in != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed self-checking bench for serial_sub_ctrl (WIDTH=8)
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             fs_a;
  logic             fs_b;
  logic             fs_bo;
  logic             fs_d;
  logic             fs_bi;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural 1-bit full subtractor closing the loop.
  assign fs_d  = fs_a ^ fs_b ^ fs_bo;
  assign fs_bi = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bo);

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .a_in          (a),
    .b_in          (b),
    .borrow_in     (bin),
    .busy_out      (busy),
    .done_out      (done),
    .diff_out      (diff),
    .borrow_out    (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf_out       (ovf),
`endif
    .fs_a_out      (fs_a),
    .fs_b_out      (fs_b),
    .fs_borrow_out (fs_bo),
    .fs_diff_in    (fs_d),
    .fs_borrow_in  (fs_bi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and watch 12 edges; edge 1 is the start edge.
  // Optionally re-pulse start with a=0xAA at edge inject (0 = none).
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tbin, input logic [7:0] exp_diff, input logic exp_bout,
                        input int inject);
    int done_at = 0;
    int pulses  = 0;
    int busy_n  = 0;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    chk({tag, "_fs_a"}, fs_a, ta[0]);
    chk({tag, "_fs_b"}, fs_b, tb[0]);
    chk({tag, "_fs_bo"}, fs_bo, tbin);
    for (int e = 1; e <= 12; e++) begin
      if (e > 1) begin
        if (e == inject) begin a = 8'hAA; start = 1'b1; end
        tick();
        if (e == inject) begin a = 8'h00; start = 1'b0; end
      end
      if (done) begin pulses++; done_at = e; end
      if (busy) busy_n++;
    end
    chk({tag, "_done_edge"}, done_at, 9);
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_busy_cycles"}, busy_n, 9);
    chk({tag, "_diff"}, diff, exp_diff);
    chk({tag, "_borrow"}, bout, exp_bout);
  endtask

  initial begin
    int pulses;
    int first_at;
    int second_at;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", bout, 0);
    chk("rst_fs", {fs_a, fs_b, fs_bo}, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    run_op("op05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf_05_03", ovf, 0);
`endif
    run_op("op03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0);
    run_op("op00_00_b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0);
    run_op("op00_FF_b1", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 0);
    run_op("ignore_start", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 4);
`ifdef SERIAL_SUB_OVF_EN
    run_op("op80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 0);
    chk("ovf_80_01", ovf, 1);
`endif

    // Reset in the 4th RUN cycle
    a = 8'hF0; b = 8'h0F; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_borrow", bout, 0);
    chk("mid_rst_fs", {fs_a, fs_b, fs_bo}, 0);
    pulses = 0;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (done) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    chk("mid_rst_idle", busy, 0);
    run_op("after_rst", 8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 0);

    // start held high: back-to-back with one IDLE cycle between
    a = 8'h22; b = 8'h11; bin = 1'b0; start = 1'b1;
    pulses = 0; first_at = 0; second_at = 0;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (done) begin
        pulses++;
        if (first_at == 0) first_at = e; else second_at = e;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_first", first_at, 9);
    chk("b2b_second", second_at, 19);
    chk("b2b_diff", diff, 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
